// File: rtl/sweep_ctrl.sv
// Sweep sequencer for an external 5-bit up/down counter: load a seed, ramp up to 31,
// dwell, ramp down to 0, dwell, and repeat for a programmed number of sweeps.
module sweep_ctrl #(
    parameter int DWELL = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Start,
    input  logic       Abort,
    input  logic [4:0] Seed,
    input  logic [3:0] Sweeps,
    input  logic       High,
    input  logic       Low,
    output logic       Load,
    output logic [4:0] Cnt_In,
    output logic       Up,
    output logic       Down,
    output logic       Busy,
    output logic       Done,
    output logic [3:0] Sweep_Cnt
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RAMP_UP,
        DWELL_H,
        RAMP_DOWN,
        DWELL_L
    } state_t;

    localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

    state_t     state;
    state_t     nextState;
    logic [4:0] seedReg;
    logic [3:0] sweepsReg;
    logic [3:0] sweepCnt;
    logic [3:0] sweepNext;
    logic [7:0] dwellCnt;
    logic       doneReg;
    logic       inDwell;
    logic       dwellLast;
    logic       finalSweep;
    logic       sweepEnd;

    assign sweepNext  = sweepCnt + 4'd1;
    assign inDwell    = (state == DWELL_H) || (state == DWELL_L);
    assign dwellLast  = (dwellCnt == DWELL_LAST);
    assign finalSweep = (sweepsReg != 4'd0) && (sweepNext == sweepsReg);
    assign sweepEnd   = (state == RAMP_DOWN) && Low && !Abort;

    assign Busy      = (state != IDLE);
    assign Done      = doneReg;
    assign Cnt_In    = seedReg;
    assign Sweep_Cnt = sweepCnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Abort overrides every transition out of a busy state, including completion.
    always_comb begin
        nextState = state;
        Load      = 1'b0;
        Up        = 1'b0;
        Down      = 1'b0;
        case (state)
            IDLE: begin
                if (Start) nextState = LOAD;
            end
            LOAD: begin
                Load      = 1'b1;
                nextState = RAMP_UP;
            end
            RAMP_UP: begin
                Up = !High;
                if (High) nextState = DWELL_H;
            end
            DWELL_H: begin
                if (dwellLast) nextState = RAMP_DOWN;
            end
            RAMP_DOWN: begin
                Down = !Low;
                if (Low) nextState = finalSweep ? IDLE : DWELL_L;
            end
            DWELL_L: begin
                if (dwellLast) nextState = RAMP_UP;
            end
            default: nextState = IDLE;
        endcase
        if (Abort && (state != IDLE)) nextState = IDLE;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            seedReg   <= 5'd0;
            sweepsReg <= 4'd0;
            sweepCnt  <= 4'd0;
            dwellCnt  <= 8'd0;
            doneReg   <= 1'b0;
        end else begin
            doneReg <= sweepEnd && finalSweep;
            if ((state == IDLE) && Start) begin
                seedReg   <= Seed;
                sweepsReg <= Sweeps;
                sweepCnt  <= 4'd0;
            end else if (sweepEnd) begin
                sweepCnt <= sweepNext;
            end
            // The dwell counter only runs inside a dwell state and restarts at every entry.
            if (inDwell && !dwellLast && !Abort) begin
                dwellCnt <= dwellCnt + 8'd1;
            end else begin
                dwellCnt <= 8'd0;
            end
        end
    end

endmodule

// File: tb/tb_sweep_ctrl.sv
// Randomized bench for sweep_ctrl driving a modelled 5-bit up/down counter; expected
// command-cycle totals per sequence come from the sweep arithmetic, not the FSM.
module tb_sweep_ctrl;

    localparam int DWELL = 4;

    logic       CLK = 1'b0;
    logic       RST;
    logic       Start;
    logic       Abort;
    logic [4:0] Seed;
    logic [3:0] Sweeps;
    logic       High;
    logic       Low;
    logic       Load;
    logic [4:0] Cnt_In;
    logic       Up;
    logic       Down;
    logic       Busy;
    logic       Done;
    logic [3:0] Sweep_Cnt;

    logic [4:0] counterValue;
    logic [4:0] expSeed;
    bit         monitorOn;
    int checks   = 0;
    int failures = 0;
    int nLoad, nUp, nDown, nQuiet, nDone, nCntIn;
    int nMutex = 0;

    always #5 CLK = ~CLK;

    sweep_ctrl #(.DWELL(DWELL)) dut (
        .CLK(CLK), .RST(RST), .Start(Start), .Abort(Abort), .Seed(Seed),
        .Sweeps(Sweeps), .High(High), .Low(Low), .Load(Load), .Cnt_In(Cnt_In),
        .Up(Up), .Down(Down), .Busy(Busy), .Done(Done), .Sweep_Cnt(Sweep_Cnt)
    );

    always @(posedge CLK or posedge RST) begin
        if (RST)       counterValue <= 5'd0;
        else if (Load) counterValue <= Cnt_In;
        else if (Up)   counterValue <= counterValue + 5'd1;
        else if (Down) counterValue <= counterValue - 5'd1;
    end
    assign High = (counterValue == 5'd31);
    assign Low  = (counterValue == 5'd0);

    always @(negedge CLK) begin
        if (!RST && (int'(Load) + int'(Up) + int'(Down) > 1)) nMutex++;
        if (monitorOn) begin
            if (Load) begin
                nLoad++;
                if (Cnt_In != expSeed) nCntIn++;
            end
            if (Up)   nUp++;
            if (Down) nDown++;
            if (Busy && !Load && !Up && !Down) nQuiet++;
            if (Done) nDone++;
        end
    end

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic startSequence(input int seed, input int sweeps);
        @(negedge CLK);
        Seed      = 5'(seed);
        Sweeps    = 4'(sweeps);
        Start     = 1'b1;
        expSeed   = 5'(seed);
        nLoad = 0; nUp = 0; nDown = 0; nQuiet = 0; nDone = 0; nCntIn = 0;
        monitorOn = 1'b1;
        @(negedge CLK);
        Start  = 1'b0;
        Seed   = 5'($urandom);
        Sweeps = 4'($urandom);
    endtask

    // Run one complete sequence and compare its cycle totals with the sweep arithmetic.
    task automatic applyStimulus(input int seed, input int sweeps, input bit pokeStart);
        int guard = 0;
        int expUp, expDown, expQuiet;
        startSequence(seed, sweeps);
        while (!Done && guard < 5000) begin
            @(negedge CLK);
            guard++;
            if (!Done) Start = pokeStart && Busy && ($urandom_range(0, 3) == 0);
        end
        Start = 1'b0;
        #1;
        expUp    = (31 - seed) + (sweeps - 1) * 31;
        expDown  = 31 * sweeps;
        expQuiet = sweeps * (DWELL + 2) + (sweeps - 1) * DWELL;
        checkOutput("done_seen", int'(Done), 1);
        checkOutput("busy_at_done", int'(Busy), 0);
        checkOutput("load_cycles", nLoad, 1);
        checkOutput("up_cycles", nUp, expUp);
        checkOutput("down_cycles", nDown, expDown);
        checkOutput("quiet_cycles", nQuiet, expQuiet);
        checkOutput("cnt_in_bad", nCntIn, 0);
        checkOutput("sweep_cnt", int'(Sweep_Cnt), sweeps);
        checkOutput("counter_end", int'(counterValue), 0);
        @(negedge CLK);
        #1;
        checkOutput("done_pulses", nDone, 1);
        checkOutput("done_after", int'(Done), 0);
        monitorOn = 1'b0;
    endtask

    initial begin
        int guard;
        int completions;
        bit prevDown;
        bit pending;

        RST = 1'b0; Start = 1'b0; Abort = 1'b0; Seed = 5'd0; Sweeps = 4'd0;
        monitorOn = 1'b0;
        #1 RST = 1'b1;
        #2;
        checkOutput("rst_busy", int'(Busy), 0);
        checkOutput("rst_load", int'(Load), 0);
        checkOutput("rst_up_down", int'(Up) + int'(Down), 0);
        checkOutput("rst_done", int'(Done), 0);
        checkOutput("rst_sweep_cnt", int'(Sweep_Cnt), 0);
        checkOutput("rst_cnt_in", int'(Cnt_In), 0);
        repeat (2) @(negedge CLK);
        RST = 1'b0;

        $display("[TB] directed sequences");
        applyStimulus(29, 1, 1'b0);
        applyStimulus(31, 2, 1'b0);

        $display("[TB] random sequences with Start pokes while busy");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(int'($urandom_range(0, 31)), int'($urandom_range(1, 3)), 1'b1);
        end

        $display("[TB] endless mode with abort after 20 sweeps");
        startSequence(int'($urandom_range(0, 31)), 0);
        guard = 0; completions = 0; prevDown = 1'b0; pending = 1'b0;
        while (completions < 20 && guard < 4000) begin
            @(negedge CLK);
            guard++;
            if (pending) begin
                checkOutput("sweep_cnt_run", int'(Sweep_Cnt), completions % 16);
                pending = 1'b0;
            end
            if (Busy && prevDown && !Down) begin
                completions++;
                pending = 1'b1;
            end
            prevDown = Down;
        end
        checkOutput("sweeps_reached", completions, 20);
        @(negedge CLK);
        checkOutput("sweep_cnt_20", int'(Sweep_Cnt), 4);
        checkOutput("busy_in_dwell", int'(Busy), 1);
        Abort = 1'b1;
        @(negedge CLK);
        Abort = 1'b0;
        checkOutput("abort_busy", int'(Busy), 0);
        checkOutput("abort_done", int'(Done), 0);
        checkOutput("abort_sweep_cnt", int'(Sweep_Cnt), 4);
        @(negedge CLK);
        checkOutput("abort_done_later", nDone, 0);
        checkOutput("abort_hold_cnt", int'(Sweep_Cnt), 4);
        monitorOn = 1'b0;

        $display("[TB] abort on the completing Low cycle");
        startSequence(int'($urandom_range(0, 31)), 1);
        guard = 0; prevDown = 1'b0;
        while (!(Busy && prevDown && !Down) && guard < 500) begin
            prevDown = Down;
            @(negedge CLK);
            guard++;
        end
        checkOutput("final_low_seen", int'(Low), 1);
        Abort = 1'b1;
        @(negedge CLK);
        Abort = 1'b0;
        checkOutput("late_abort_busy", int'(Busy), 0);
        checkOutput("late_abort_done", int'(Done), 0);
        checkOutput("late_abort_cnt", int'(Sweep_Cnt), 0);
        @(negedge CLK);
        checkOutput("late_abort_pulses", nDone, 0);
        monitorOn = 1'b0;

        $display("[TB] Start and Abort together in IDLE");
        @(negedge CLK);
        Seed = 5'd17; Start = 1'b1; Abort = 1'b1;
        @(negedge CLK);
        Start = 1'b0;
        checkOutput("both_load", int'(Load), 1);
        checkOutput("both_cnt_in", int'(Cnt_In), 17);
        @(negedge CLK);
        Abort = 1'b0;
        checkOutput("load_abort_busy", int'(Busy), 0);
        checkOutput("load_abort_done", int'(Done), 0);

        $display("[TB] reset pulse in the middle of a ramp");
        startSequence(int'($urandom_range(0, 20)), 2);
        guard = 0;
        while (!Up && guard < 20) begin
            @(negedge CLK);
            guard++;
        end
        checkOutput("ramp_up_seen", int'(Up), 1);
        repeat (2) @(negedge CLK);
        #2 RST = 1'b1;
        #1;
        checkOutput("midrst_up", int'(Up), 0);
        checkOutput("midrst_busy", int'(Busy), 0);
        checkOutput("midrst_load_down", int'(Load) + int'(Down), 0);
        checkOutput("midrst_done", int'(Done), 0);
        checkOutput("midrst_cnt_in", int'(Cnt_In), 0);
        #1 RST = 1'b0;
        monitorOn = 1'b0;
        @(negedge CLK);
        checkOutput("post_rst_idle", int'(Busy), 0);
        checkOutput("post_rst_done", int'(Done), 0);
        applyStimulus(int'($urandom_range(0, 31)), 2, 1'b1);

        checkOutput("cmd_mutex", nMutex, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sweep_ctrl.md
SWEEP_CTRL -- requirements
Module: sweep_ctrl

Interface
REQ-001 Parameter: DWELL, default 4, dwell length in cycles at each end of a sweep; legal range 1..255.
REQ-002 CLK  input  1  single clock; all state changes on its rising edge.
REQ-003 RST  input  1  asynchronous, active-high reset.
REQ-004 Start  input  1  begin a sweep sequence; sampled in IDLE only.
REQ-005 Abort  input  1  terminate the sequence; sampled in any non-IDLE state.
REQ-006 Seed  input  5  starting count, loaded into the counter.
REQ-007 Sweeps  input  4  number of full up-then-down sweeps; 0 = run until Abort.
REQ-008 High  input  1  counter-at-31 flag from the up/down counter.
REQ-009 Low  input  1  counter-at-0 flag from the up/down counter.
REQ-010 Load  output  1  counter load command.
REQ-011 Cnt_In  output  5  counter load value.
REQ-012 Up  output  1  counter increment command.
REQ-013 Down  output  1  counter decrement command.
REQ-014 Busy  output  1  high in every non-IDLE state.
REQ-015 Done  output  1  one-cycle pulse on normal completion.
REQ-016 Sweep_Cnt  output  4  completed sweeps in the current or last sequence.

Function
REQ-017 States: IDLE, LOAD, RAMP_UP, DWELL_H, RAMP_DOWN, DWELL_L.
REQ-018 IDLE with Start=1 -> LOAD; Seed and Sweeps latched; Sweep_Cnt cleared to 0.
REQ-019 LOAD lasts exactly 1 cycle: Load=1, Cnt_In=latched Seed -> RAMP_UP.
REQ-020 Cnt_In always drives the latched Seed; counter responds only while Load=1.
REQ-021 RAMP_UP: Up = !High (combinational); with High=1 -> DWELL_H.
REQ-022 DWELL_H lasts exactly DWELL cycles, all commands low -> RAMP_DOWN.
REQ-023 RAMP_DOWN: Down = !Low (combinational); with Low=1, Sweep_Cnt increments (4-bit, wraps 15->0).
REQ-024 RAMP_DOWN exit: Sweeps!=0 and incremented Sweep_Cnt==Sweeps -> IDLE with Done=1 next cycle; else -> DWELL_L.
REQ-025 DWELL_L lasts exactly DWELL cycles, all commands low -> RAMP_UP.
REQ-026 Load, Up and Down are mutually exclusive in every cycle.
REQ-027 Seed=31: RAMP_UP sees High in its first cycle, asserts no Up, goes to DWELL_H.
REQ-028 Abort=1 in any non-IDLE state -> IDLE next edge; Done not pulsed; commands deasserted in IDLE; Sweep_Cnt holds.
REQ-029 Abort has priority over every other transition, including completion in RAMP_DOWN.
REQ-030 Start in a non-IDLE state is ignored; Start and Abort both high in IDLE -> LOAD.
REQ-031 Done is registered, high only in the first IDLE cycle after completion.
REQ-032 Sweep_Cnt holds its value in IDLE until the next accepted Start.

Reset
REQ-033 RST=1 forces IDLE immediately, independent of CLK.
REQ-034 During and after RST: Load=Up=Down=Busy=Done=0, Sweep_Cnt=0, latched Seed=0, latched Sweeps=0, dwell counter=0.
REQ-035 RST asserted mid-sweep abandons the sequence; no Done; first post-reset cycle is IDLE.

Verification
REQ-036 Seed=29, Sweeps=1, DWELL=4, real counter attached -> Load 1 cycle; Up exactly 2 cycles; 4 dwell cycles; Down exactly 31 cycles; Done pulses once; Sweep_Cnt=1.
REQ-037 Seed=31, Sweeps=2 -> zero Up cycles on the first ramp; two full sweeps; Done pulses with Sweep_Cnt=2; Down total 62 cycles.
REQ-038 Sweeps=0, run 20 sweeps, then Abort -> Sweep_Cnt wraps 15->0 and reads 4; IDLE next cycle; Done stays 0.
REQ-039 Abort in the cycle Low=1 on the final sweep -> IDLE; Done=0; Sweep_Cnt unchanged.
REQ-040 RST pulse mid-RAMP_UP, between clock edges -> all outputs 0 immediately; IDLE; Start afterward runs a clean sequence.
REQ-041 Start pulsed while Busy=1 -> no effect; every cycle checks at most one of Load/Up/Down high.
